// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: requester indices and default widths.
package dmem_arbiter_pkg;

    typedef enum logic {
        PORT_CPU = 1'b0,
        PORT_LDR = 1'b1
    } port_e;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_ADDR_W = 14;

endpackage

// File: rtl/dmem_arbiter.sv
// Shares single-port data memory between the CPU (priority) and the UART loader,
// bounding CPU back-to-back wins while the loader waits; tracks 1-cycle read latency.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W    = DEFAULT_ADDR_W,
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int MAX_BURST = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic              cpu_stall,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [31:0]       ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic              ldr_gnt,
    output logic              ldr_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);

    logic [3:0] burst_cnt;
    logic       rd_pend;
    port_e      rd_owner;
    logic       ldr_sel;
    logic       sel_we;
    logic       unused_addr_bits;

    // Byte offset and address bits above the memory's reach are dropped by design.
    assign unused_addr_bits = ^{cpu_addr[31:ADDR_W+2], cpu_addr[1:0],
                                ldr_addr[31:ADDR_W+2], ldr_addr[1:0]};

    always_comb begin
        ldr_sel   = ldr_req & (~cpu_req | (burst_cnt == BURST_LIMIT));
        ldr_gnt   = ~reset & ldr_sel;
        cpu_gnt   = ~reset & cpu_req & ~ldr_sel;
        cpu_stall = cpu_req & ~cpu_gnt;

        sel_we    = cpu_we;
        mem_addr  = cpu_addr[ADDR_W+1:2];
        mem_wdata = cpu_wdata;
        if (ldr_gnt) begin
            sel_we    = ldr_we;
            mem_addr  = ldr_addr[ADDR_W+1:2];
            mem_wdata = ldr_wdata;
        end
        mem_we = sel_we & (cpu_gnt | ldr_gnt);

        // Gating with reset drops a read whose response would land in the reset cycle.
        cpu_rvalid = ~reset & rd_pend & (rd_owner == PORT_CPU);
        ldr_rvalid = ~reset & rd_pend & (rd_owner == PORT_LDR);
        rdata      = mem_rdata;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            burst_cnt <= '0;
            rd_pend   <= 1'b0;
            rd_owner  <= PORT_CPU;
        end else begin
            if (ldr_gnt || !ldr_req) begin
                burst_cnt <= '0;
            end else if (cpu_gnt && burst_cnt != BURST_LIMIT) begin
                burst_cnt <= burst_cnt + 4'd1;
            end
            rd_pend  <= (cpu_gnt | ldr_gnt) & ~sel_we;
            rd_owner <= ldr_gnt ? PORT_LDR : PORT_CPU;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: behavioural model checked every cycle plus literal expectations.
module tb_dmem_arbiter;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 32;
    localparam int MB     = 4;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              cpu_req = 1'b0, cpu_we = 1'b0;
    logic [31:0]       cpu_addr = '0;
    logic [DATA_W-1:0] cpu_wdata = '0;
    logic              ldr_req = 1'b0, ldr_we = 1'b0;
    logic [31:0]       ldr_addr = '0;
    logic [DATA_W-1:0] ldr_wdata = '0;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              cpu_gnt, cpu_rvalid, cpu_stall, ldr_gnt, ldr_rvalid, mem_we;
    logic [DATA_W-1:0] rdata, mem_wdata;
    logic [ADDR_W-1:0] mem_addr;

    int n_cmp = 0;
    int n_bad = 0;

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MB)) dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_stall(cpu_stall),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_gnt(ldr_gnt), .ldr_rvalid(ldr_rvalid), .rdata(rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: count of CPU wins in a row while the loader waits, and who owns the read in flight.
    int streak   = 0;
    int pend_own = -1;   // -1 none, 0 CPU, 1 loader

    function automatic bit want_ldr();
        return !reset && ldr_req && (!cpu_req || streak >= MB);
    endfunction

    function automatic bit want_cpu();
        return !reset && cpu_req && !want_ldr();
    endfunction

    always @(posedge clock) begin
        bit l, c;
        l = want_ldr();
        c = want_cpu();
        if (reset) begin
            streak   = 0;
            pend_own = -1;
        end else begin
            if (l && !ldr_we)      pend_own = 1;
            else if (c && !cpu_we) pend_own = 0;
            else                   pend_own = -1;
            if (l || !ldr_req)     streak = 0;
            else if (c)            streak = (streak + 1 > MB) ? MB : streak + 1;
        end
    end

    always @(negedge clock) begin
        bit l, c;
        l = want_ldr();
        c = want_cpu();
        check("cpu_gnt", 64'(cpu_gnt), 64'(c));
        check("ldr_gnt", 64'(ldr_gnt), 64'(l));
        check("cpu_stall", 64'(cpu_stall), 64'(cpu_req && !c));
        check("mem_we", 64'(mem_we), 64'(l ? ldr_we : (c && cpu_we)));
        if (l) begin
            check("mem_addr", 64'(mem_addr), 64'((ldr_addr >> 2) % (1 << ADDR_W)));
            check("mem_wdata", 64'(mem_wdata), 64'(ldr_wdata));
        end else if (c) begin
            check("mem_addr", 64'(mem_addr), 64'((cpu_addr >> 2) % (1 << ADDR_W)));
            check("mem_wdata", 64'(mem_wdata), 64'(cpu_wdata));
        end
        check("cpu_rvalid", 64'(cpu_rvalid), 64'(!reset && pend_own == 0));
        check("ldr_rvalid", 64'(ldr_rvalid), 64'(!reset && pend_own == 1));
        check("rdata", 64'(rdata), 64'(mem_rdata));
    end

    task automatic cyc(input logic r,
                       input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                       input logic lr, input logic lw, input logic [31:0] la, input logic [31:0] ld,
                       input logic [31:0] md);
        @(posedge clock);
        #1;
        reset = r;
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        ldr_req = lr; ldr_we = lw; ldr_addr = la; ldr_wdata = ld;
        mem_rdata = md;
        @(negedge clock);
    endtask

    initial begin
        bit seq_ldr [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

        // Reset with a CPU write pending: nothing may be granted or written.
        cyc(1, 1, 1, 32'h40, 32'h1, 1, 1, 32'h80, 32'h2, 32'h0);
        check("rst_cpu_gnt", 64'(cpu_gnt), 64'd0);
        check("rst_ldr_gnt", 64'(ldr_gnt), 64'd0);
        check("rst_mem_we", 64'(mem_we), 64'd0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("rst_rvalid", 64'({cpu_rvalid, ldr_rvalid}), 64'd0);

        // CPU read of 0x10.
        cyc(0, 1, 0, 32'h0000_0010, 0, 0, 0, 0, 0, 0);
        check("rd_cpu_gnt", 64'(cpu_gnt), 64'd1);
        check("rd_mem_addr", 64'(mem_addr), 64'd4);
        check("rd_mem_we", 64'(mem_we), 64'd0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF);
        check("rd_cpu_rvalid", 64'(cpu_rvalid), 64'd1);
        check("rd_rdata", 64'(rdata), 64'hDEADBEEF);
        check("rd_ldr_rvalid", 64'(ldr_rvalid), 64'd0);

        // Loader-only write.
        cyc(0, 0, 0, 0, 0, 1, 1, 32'h0000_0104, 32'h12345678, 0);
        check("lw_ldr_gnt", 64'(ldr_gnt), 64'd1);
        check("lw_mem_we", 64'(mem_we), 64'd1);
        check("lw_mem_addr", 64'(mem_addr), 64'h41);
        check("lw_mem_wdata", 64'(mem_wdata), 64'h12345678);
        check("lw_cpu_stall", 64'(cpu_stall), 64'd0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h5555AAAA);
        check("lw_no_rvalid", 64'({cpu_rvalid, ldr_rvalid}), 64'd0);

        // Both requesting continuously: C,C,C,C,L,C,C,C,C,L.
        for (int i = 0; i < 10; i++) begin
            cyc(0, 1, 1, 32'h200 + 32'(i * 4), 32'(i), 1, 1, 32'h300, 32'hA5, 0);
            check("burst_ldr_gnt", 64'(ldr_gnt), 64'(seq_ldr[i]));
            check("burst_cpu_gnt", 64'(cpu_gnt), 64'(!seq_ldr[i]));
            check("burst_cpu_stall", 64'(cpu_stall), 64'(seq_ldr[i]));
        end
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Alternating reads: CPU at T, loader at T+1.
        cyc(0, 1, 0, 32'h20, 0, 0, 0, 0, 0, 32'h0);
        cyc(0, 0, 0, 0, 0, 1, 0, 32'h24, 0, 32'hAAAA0001);
        check("alt_cpu_rvalid", 64'(cpu_rvalid), 64'd1);
        check("alt_rdata1", 64'(rdata), 64'hAAAA0001);
        check("alt_ldr_rvalid0", 64'(ldr_rvalid), 64'd0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hBBBB0002);
        check("alt_ldr_rvalid", 64'(ldr_rvalid), 64'd1);
        check("alt_cpu_rvalid0", 64'(cpu_rvalid), 64'd0);
        check("alt_rdata2", 64'(rdata), 64'hBBBB0002);

        // Build a CPU streak of two, then a read grant followed by reset.
        cyc(0, 1, 1, 32'h30, 1, 1, 1, 32'h34, 2, 0);
        cyc(0, 1, 0, 32'h38, 0, 1, 1, 32'h34, 2, 0);
        check("rr_cpu_gnt", 64'(cpu_gnt), 64'd1);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'hCAFE0000);
        check("rr_rvalid_t1", 64'(cpu_rvalid), 64'd0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hCAFE0001);
        check("rr_rvalid_t2", 64'(cpu_rvalid), 64'd0);
        // A cleared burst count means four CPU wins again before the loader gets in.
        for (int i = 0; i < 5; i++) begin
            cyc(0, 1, 1, 32'h40, 0, 1, 1, 32'h44, 0, 0);
            check("rr_burst_ldr", 64'(ldr_gnt), 64'(i == 4));
        end
        cyc(0, 1, 0, 32'h48, 0, 0, 0, 0, 0, 0);
        check("rr_cpu_regrant", 64'(cpu_gnt), 64'd1);

        // Misaligned/high addresses.
        cyc(0, 1, 1, 32'hFFFF_0007, 32'h77, 0, 0, 0, 0, 0);
        check("hi_mem_addr", 64'(mem_addr), 64'h0001);
        check("hi_mem_we", 64'(mem_we), 64'd1);
        cyc(0, 1, 1, 32'h0000_F00E, 32'h78, 0, 0, 0, 0, 0);
        check("hi_mem_addr2", 64'(mem_addr), 64'h3C03);

        // Simultaneous writes: CPU wins, loader waits and goes next once the CPU drops.
        cyc(0, 1, 1, 32'h50, 32'h11, 1, 1, 32'h60, 32'h22, 0);
        check("ww_cpu_gnt", 64'(cpu_gnt), 64'd1);
        cyc(0, 0, 0, 0, 0, 1, 1, 32'h60, 32'h22, 0);
        check("ww_ldr_wdata", 64'(mem_wdata), 64'h22);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
